// File: rtl/road_rage_game_ctrl_if.sv
// Signal bundle between the Road Rage game logic and the game-flow controller.
// master: road/button side driving requests; slave: the controller itself.
interface road_rage_game_ctrl_if;
  logic       start_btn;
  logic       pause_btn;
  logic       crash;
  logic       timer_en;
  logic       timer_resetn;
  logic [2:0] state;
  logic [3:0] countdown;
  logic [2:0] lives;
  logic       game_over;

  modport master (
    output start_btn, pause_btn, crash,
    input  timer_en, timer_resetn, state, countdown, lives, game_over
  );

  modport slave (
    input  start_btn, pause_btn, crash,
    output timer_en, timer_resetn, state, countdown, lives, game_over
  );
endinterface

// File: rtl/road_rage_game_ctrl.sv
// Road Rage game-flow controller: idle, countdown, run, pause, crash recovery, game over.
// Drives the elapsed-time display counter's enable and active-low clear and tracks lives.
// Optional feature macro: GAME_CTRL_PAUSE_EN compiles in the PAUSE state and pause_btn handling.
// All outputs are registered; there is no combinational path from inputs to outputs.
module road_rage_game_ctrl #(
  parameter int unsigned TICK_COUNT     = 50000000,
  parameter int unsigned COUNTDOWN_SECS = 3,
  parameter int unsigned LIVES          = 3
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  road_rage_game_ctrl_if.slave  game_io
);

  localparam int unsigned      TickW     = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [TickW-1:0] TickMax   = TickW'(TICK_COUNT - 1);
  localparam logic [3:0]       CdInit    = 4'(COUNTDOWN_SECS);
  localparam logic [2:0]       LivesInit = 3'(LIVES);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StRun       = 3'd2,
    StPause     = 3'd3,
    StHit       = 3'd4,
    StOver      = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       countdown_q, countdown_d;
  logic [2:0]       lives_q, lives_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             timer_en_q, timer_resetn_q, game_over_q;
  logic             tick;

  logic start_in_q, start_prev_q, start_edge;
  logic crash_in_q, crash_prev_q, crash_edge;
`ifdef GAME_CTRL_PAUSE_EN
  logic pause_in_q, pause_prev_q, pause_edge;
`else
  logic unused_pause;
  assign unused_pause = game_io.pause_btn;
`endif

  // Sample each request once, then compare against the previous sample for a rising edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      start_in_q   <= 1'b0;
      start_prev_q <= 1'b0;
      crash_in_q   <= 1'b0;
      crash_prev_q <= 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
      pause_in_q   <= 1'b0;
      pause_prev_q <= 1'b0;
`endif
    end else begin
      start_in_q   <= game_io.start_btn;
      start_prev_q <= start_in_q;
      crash_in_q   <= game_io.crash;
      crash_prev_q <= crash_in_q;
`ifdef GAME_CTRL_PAUSE_EN
      pause_in_q   <= game_io.pause_btn;
      pause_prev_q <= pause_in_q;
`endif
    end
  end

  assign start_edge = start_in_q & ~start_prev_q;
  assign crash_edge = crash_in_q & ~crash_prev_q;
`ifdef GAME_CTRL_PAUSE_EN
  assign pause_edge = pause_in_q & ~pause_prev_q;
`endif

  assign tick = (tick_cnt_q == TickMax);

  // Next-state, countdown and lives; the seconds counter restarts on every state change.
  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    lives_d     = lives_q;
    case (state_q)
      StIdle: begin
        lives_d     = LivesInit;
        countdown_d = 4'd0;
        if (start_edge) begin
          state_d     = StCountdown;
          countdown_d = CdInit;
        end
      end
      StCountdown: begin
        if (tick) begin
          if (countdown_q <= 4'd1) begin
            state_d     = StRun;
            countdown_d = 4'd0;
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end
      end
      StRun: begin
        // Crash takes priority over a simultaneous pause.
        if (crash_edge) begin
          if (lives_q > 3'd1) begin
            state_d = StHit;
            lives_d = lives_q - 3'd1;
          end else begin
            state_d = StOver;
            lives_d = 3'd0;
          end
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (pause_edge) begin
          state_d = StPause;
        end
`endif
      end
`ifdef GAME_CTRL_PAUSE_EN
      StPause: begin
        if (pause_edge) begin
          state_d = StRun;
        end
      end
`endif
      StHit: begin
        if (tick) begin
          state_d = StRun;
        end
      end
      StOver: begin
        if (start_edge) begin
          state_d = StIdle;
          lives_d = LivesInit;
        end
      end
      default: begin
        state_d     = StIdle;
        countdown_d = 4'd0;
        lives_d     = LivesInit;
      end
    endcase

    if ((state_d != state_q) || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TickW'(1);
    end
  end

  // FSM registers; Moore outputs are decoded from the next state so they track state_q exactly.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= StIdle;
      countdown_q    <= 4'd0;
      lives_q        <= LivesInit;
      tick_cnt_q     <= '0;
      timer_en_q     <= 1'b0;
      timer_resetn_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      countdown_q    <= countdown_d;
      lives_q        <= lives_d;
      tick_cnt_q     <= tick_cnt_d;
      timer_en_q     <= (state_d == StRun);
      timer_resetn_q <= (state_d != StIdle);
      game_over_q    <= (state_d == StOver);
    end
  end

  assign game_io.state        = state_q;
  assign game_io.countdown    = countdown_q;
  assign game_io.lives        = lives_q;
  assign game_io.timer_en     = timer_en_q;
  assign game_io.timer_resetn = timer_resetn_q;
  assign game_io.game_over    = game_over_q;

endmodule

// File: tb/tb_road_rage_game_ctrl.sv
// Self-checking bench for road_rage_game_ctrl: directed scenarios plus random stimulus,
// all compared against a time-in-state reference model of the game rules.
module tb_road_rage_game_ctrl;

  localparam int TICK = 4;
  localparam int CDS  = 3;
  localparam int NL   = 3;
`ifdef GAME_CTRL_PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  localparam int SIdle = 0, SCd = 1, SRun = 2, SPause = 3, SHit = 4, SOver = 5;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  road_rage_game_ctrl_if game_if ();

  road_rage_game_ctrl #(
    .TICK_COUNT    (TICK),
    .COUNTDOWN_SECS(CDS),
    .LIVES         (NL)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .game_io (game_if)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: state, lives and cycles spent in the current state.
  int m_state   = SIdle;
  int m_lives   = NL;
  int m_elapsed = 0;
  // Input sample history: x1 = sampled one edge ago, x2 = two edges ago.
  bit hs1, hs2, hp1, hp2, hc1, hc2;

  logic [12:0] obs;
  assign obs = {game_if.state, game_if.countdown, game_if.lives,
                game_if.timer_en, game_if.timer_resetn, game_if.game_over};

  task automatic model_step(input bit rst, input bit s, input bit p, input bit c);
    bit se, pe, ce;
    int nxt;
    if (rst) begin
      m_state = SIdle; m_lives = NL; m_elapsed = 0;
      hs1 = 0; hs2 = 0; hp1 = 0; hp2 = 0; hc1 = 0; hc2 = 0;
      return;
    end
    // A level sampled high after a low sample acts one edge later.
    se = hs1 && !hs2;
    pe = hp1 && !hp2 && PauseEn;
    ce = hc1 && !hc2;
    hs2 = hs1; hs1 = s;
    hp2 = hp1; hp1 = p;
    hc2 = hc1; hc1 = c;
    m_elapsed++;
    nxt = m_state;
    case (m_state)
      SIdle:  if (se) nxt = SCd;
      SCd:    if (m_elapsed == CDS * TICK) nxt = SRun;
      SRun: begin
        if (ce) begin
          if (m_lives > 1) begin m_lives--; nxt = SHit; end
          else begin m_lives = 0; nxt = SOver; end
        end else if (pe) begin
          nxt = SPause;
        end
      end
      SPause: if (pe) nxt = SRun;
      SHit:   if (m_elapsed == TICK) nxt = SRun;
      SOver:  if (se) nxt = SIdle;
      default: nxt = SIdle;
    endcase
    if (nxt == SIdle) m_lives = NL;
    if (nxt != m_state) m_elapsed = 0;
    m_state = nxt;
  endtask

  function automatic logic [12:0] exp_vec();
    logic [3:0] cd;
    cd = (m_state == SCd) ? 4'(CDS - m_elapsed / TICK) : 4'd0;
    return {3'(m_state), cd, 3'(m_lives), m_state == SRun, m_state != SIdle, m_state == SOver};
  endfunction

  // Advance one clock: model sees the inputs present at the edge; return at the falling edge.
  task automatic clk_step();
    @(posedge CLOCK_50);
    model_step(reset, game_if.start_btn, game_if.pause_btn, game_if.crash);
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    game_if.start_btn = 1'b0; game_if.pause_btn = 1'b0; game_if.crash = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clk_step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL reset_model cyc %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (obs !== {3'd0, 4'd0, 3'(NL), 1'b0, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL reset_values: got %h want %h", obs, {3'd0, 4'd0, 3'(NL), 3'b000});
    end
    reset = 1'b0;
  endtask

  task automatic test_countdown();
    int n = 0;
    game_if.start_btn = 1'b1; clk_step(); game_if.start_btn = 1'b0;
    while (game_if.state !== 3'(SCd) && n < 8) begin clk_step(); n++; end
    vectors++;
    if (n !== 1 || game_if.countdown !== 4'(CDS)) begin
      miscompares++;
      $display("FAIL countdown_entry: got wait %0d cd %0d want wait 1 cd %0d", n, game_if.countdown, CDS);
    end
    for (int i = 1; i <= CDS * TICK; i++) begin
      clk_step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL countdown_model cyc %0d: got %h want %h", i, obs, exp_vec());
      end
      if (i == TICK || i == 2 * TICK) begin
        vectors++;
        if (game_if.countdown !== 4'(CDS - i / TICK)) begin
          miscompares++;
          $display("FAIL countdown_value cyc %0d: got %0d want %0d", i, game_if.countdown, CDS - i / TICK);
        end
      end
      if (i == CDS * TICK - 1 || i == CDS * TICK) begin
        vectors++;
        if (game_if.state !== 3'((i == CDS * TICK) ? SRun : SCd) ||
            game_if.timer_en !== (i == CDS * TICK)) begin
          miscompares++;
          $display("FAIL countdown_to_run cyc %0d: got state %0d en %b", i, game_if.state, game_if.timer_en);
        end
      end
    end
  endtask

  task automatic test_crash();
    for (int k = 1; k <= NL; k++) begin
      clk_step(); clk_step();
      game_if.crash = 1'b1; clk_step(); game_if.crash = 1'b0; clk_step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL crash_model k %0d: got %h want %h", k, obs, exp_vec());
      end
      vectors++;
      if (k < NL) begin
        if (game_if.state !== 3'(SHit) || game_if.lives !== 3'(NL - k) || game_if.timer_en !== 1'b0) begin
          miscompares++;
          $display("FAIL crash_hit k %0d: got state %0d lives %0d want state %0d lives %0d",
                   k, game_if.state, game_if.lives, SHit, NL - k);
        end
        for (int i = 1; i <= TICK; i++) begin
          clk_step();
          vectors++;
          if (obs !== exp_vec()) begin
            miscompares++; $display("FAIL hit_model cyc %0d: got %h want %h", i, obs, exp_vec());
          end
        end
        vectors++;
        if (game_if.state !== 3'(SRun)) begin
          miscompares++; $display("FAIL hit_length: got state %0d want %0d", game_if.state, SRun);
        end
      end else begin
        if (game_if.state !== 3'(SOver) || game_if.lives !== 3'd0 || game_if.game_over !== 1'b1 ||
            game_if.timer_resetn !== 1'b1) begin
          miscompares++; $display("FAIL crash_over: got %h want state %0d lives 0 go 1", obs, SOver);
        end
      end
    end
  endtask

  task automatic test_over_restart();
    game_if.start_btn = 1'b1; clk_step(); game_if.start_btn = 1'b0; clk_step();
    vectors++;
    if (game_if.state !== 3'(SIdle) || game_if.timer_resetn !== 1'b0 || game_if.lives !== 3'(NL) ||
        game_if.game_over !== 1'b0) begin
      miscompares++; $display("FAIL over_restart: got %h want state 0 resetn 0 lives %0d", obs, NL);
    end
  endtask

  task automatic test_start_held();
    int entries = 0;
    logic [2:0] prev = game_if.state;
    game_if.start_btn = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 20) game_if.start_btn = 1'b0;
      clk_step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL held_model cyc %0d: got %h want %h", i, obs, exp_vec());
      end
      if (prev !== 3'(SCd) && game_if.state === 3'(SCd)) entries++;
      prev = game_if.state;
    end
    vectors++;
    if (entries !== 1 || game_if.state !== 3'(SRun)) begin
      miscompares++;
      $display("FAIL start_held: got entries %0d state %0d want 1 and %0d", entries, game_if.state, SRun);
    end
  endtask

  task automatic test_back_to_back();
    bit seen_pause = 1'b0;
    game_if.crash = 1'b1; game_if.pause_btn = 1'b1; clk_step();
    game_if.crash = 1'b0; game_if.pause_btn = 1'b0;
    for (int i = 0; i < TICK + 3; i++) begin
      clk_step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL simul_model cyc %0d: got %h want %h", i, obs, exp_vec());
      end
      if (game_if.state === 3'(SPause)) seen_pause = 1'b1;
      if (i == 0) begin
        vectors++;
        if (game_if.state !== 3'(SHit) || game_if.lives !== 3'(NL - 1)) begin
          miscompares++;
          $display("FAIL simul_hit: got state %0d lives %0d want %0d %0d", game_if.state, game_if.lives, SHit, NL - 1);
        end
      end
    end
    vectors++;
    if (seen_pause || game_if.state !== 3'(SRun)) begin
      miscompares++; $display("FAIL simul_no_pause: got pause_seen %b state %0d", seen_pause, game_if.state);
    end
  endtask

  task automatic test_pause();
    int n = 0;
    game_if.pause_btn = 1'b1; clk_step(); game_if.pause_btn = 1'b0; clk_step();
    vectors++;
    if (game_if.state !== 3'(PauseEn ? SPause : SRun) || game_if.timer_en !== !PauseEn) begin
      miscompares++;
      $display("FAIL pause_enter: got state %0d en %b want %0d", game_if.state, game_if.timer_en,
               PauseEn ? SPause : SRun);
    end
    clk_step(); clk_step();
    game_if.crash = 1'b1; clk_step(); game_if.crash = 1'b0; clk_step();
    vectors++;
    if (obs !== exp_vec() || game_if.state !== 3'(PauseEn ? SPause : SHit)) begin
      miscompares++; $display("FAIL pause_crash: got %h want %h", obs, exp_vec());
    end
    clk_step();
    game_if.pause_btn = 1'b1; clk_step(); game_if.pause_btn = 1'b0; clk_step();
    while (game_if.state !== 3'(SRun) && n < 2 * TICK) begin clk_step(); n++; end
    vectors++;
    if (obs !== exp_vec() || game_if.state !== 3'(SRun)) begin
      miscompares++; $display("FAIL pause_resume: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    reset = 1'b1; clk_step(); reset = 1'b0; clk_step();
    game_if.start_btn = 1'b1; clk_step(); game_if.start_btn = 1'b0;
    while (game_if.state !== 3'(SCd) && n < 8) begin clk_step(); n++; end
    for (int i = 0; i < TICK + 1; i++) clk_step();
    vectors++;
    if (obs !== exp_vec() || game_if.state !== 3'(SCd)) begin
      miscompares++; $display("FAIL mid_setup: got %h want %h", obs, exp_vec());
    end
    reset = 1'b1; clk_step();
    vectors++;
    if (obs !== {3'd0, 4'd0, 3'(NL), 3'b000}) begin
      miscompares++; $display("FAIL reset_mid: got %h want %h", obs, {3'd0, 4'd0, 3'(NL), 3'b000});
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset             = ($urandom_range(0, 299) == 0);
      game_if.start_btn = ($urandom_range(0, 9) == 0);
      game_if.pause_btn = ($urandom_range(0, 5) == 0);
      game_if.crash     = ($urandom_range(0, 7) == 0);
      clk_step();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    reset = 1'b0;
    game_if.start_btn = 1'b0; game_if.pause_btn = 1'b0; game_if.crash = 1'b0;
  endtask

  initial begin
    game_if.start_btn = 1'b0;
    game_if.pause_btn = 1'b0;
    game_if.crash     = 1'b0;
    test_reset();
    test_countdown();
    test_crash();
    test_over_restart();
    test_start_held();
    test_back_to_back();
    test_pause();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
